// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-stage register: control bundle plus opaque payload through
// DEPTH stages, with stall, flush, valid tracking, $0-write suppression and hazard taps.
module pipe_stage_reg #(
   parameter int DATA_W   = 64,
   parameter int TNEW_W   = 2,
   parameter int DEPTH    = 1,
   parameter int TNEW_DEC = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   input  logic                    flush,
   input  logic                    valid_in,
   input  logic [31:0]             pc_in,
   input  logic [TNEW_W-1:0]       tnew_in,
   input  logic                    regwrite_in,
   input  logic [4:0]              a3_in,
   input  logic [DATA_W-1:0]       data_in,
   output logic                    valid_out,
   output logic [31:0]             pc_out,
   output logic [TNEW_W-1:0]       tnew_out,
   output logic                    regwrite_out,
   output logic [4:0]              a3_out,
   output logic [DATA_W-1:0]       data_out,
   output logic [5*DEPTH-1:0]      tap_a3,
   output logic [DEPTH-1:0]        tap_regwrite,
   output logic [TNEW_W*DEPTH-1:0] tap_tnew,
   output logic [31:0]             bubble_cnt
);

   if (DEPTH < 1 || DEPTH > 4) begin : g_depth_check
      $error("pipe_stage_reg: DEPTH must be in 1..4");
   end

   logic              valid_q    [DEPTH];
   logic [31:0]       pc_q       [DEPTH];
   logic [TNEW_W-1:0] tnew_q     [DEPTH];
   logic              regwrite_q [DEPTH];
   logic [4:0]        a3_q       [DEPTH];
   logic [DATA_W-1:0] data_q     [DEPTH];
   logic [31:0]       bubble_q;

   function automatic logic [TNEW_W-1:0] tnew_step(input logic [TNEW_W-1:0] t);
      if (TNEW_DEC != 0 && t != '0) return t - TNEW_W'(1);
      return t;
   endfunction

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int unsigned k = 0; k < DEPTH; k++) begin
            valid_q[k]    <= 1'b0;
            pc_q[k]       <= '0;
            tnew_q[k]     <= '0;
            regwrite_q[k] <= 1'b0;
            a3_q[k]       <= '0;
            data_q[k]     <= '0;
         end
         bubble_q <= '0;
      end else begin
         // Flush overrides a stall on stage 0 only; later stages still obey en.
         if (flush) begin
            valid_q[0]    <= 1'b0;
            pc_q[0]       <= pc_in;
            tnew_q[0]     <= '0;
            regwrite_q[0] <= 1'b0;
            a3_q[0]       <= '0;
            data_q[0]     <= '0;
         end else if (en) begin
            valid_q[0]    <= valid_in;
            pc_q[0]       <= pc_in;
            tnew_q[0]     <= tnew_step(tnew_in);
            regwrite_q[0] <= regwrite_in & valid_in & (a3_in != 5'd0);
            a3_q[0]       <= a3_in;
            data_q[0]     <= data_in;
         end
         if (en) begin
            for (int unsigned k = 1; k < DEPTH; k++) begin
               valid_q[k]    <= valid_q[k-1];
               pc_q[k]       <= pc_q[k-1];
               tnew_q[k]     <= tnew_step(tnew_q[k-1]);
               regwrite_q[k] <= regwrite_q[k-1] & valid_q[k-1] & (a3_q[k-1] != 5'd0);
               a3_q[k]       <= a3_q[k-1];
               data_q[k]     <= data_q[k-1];
            end
         end
         if (!valid_q[DEPTH-1] && bubble_q != '1) bubble_q <= bubble_q + 32'd1;
      end
   end

   assign valid_out    = valid_q[DEPTH-1];
   assign pc_out       = pc_q[DEPTH-1];
   assign tnew_out     = tnew_q[DEPTH-1];
   assign regwrite_out = regwrite_q[DEPTH-1];
   assign a3_out       = a3_q[DEPTH-1];
   assign data_out     = data_q[DEPTH-1];
   assign bubble_cnt   = bubble_q;

   always_comb begin
      tap_a3       = '0;
      tap_regwrite = '0;
      tap_tnew     = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         tap_a3[5*k +: 5]           = a3_q[k];
         tap_regwrite[k]            = regwrite_q[k];
         tap_tnew[TNEW_W*k +: TNEW_W] = tnew_q[k];
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: DEPTH=2 and DEPTH=1 instances on shared inputs, checked
// against a record-level pipeline model, a vector table and directed corner sequences.
module tb_pipe_stage_reg;

   logic        clk = 1'b0;
   logic        reset, en, flush, valid_in, regwrite_in;
   logic [31:0] pc_in;
   logic [1:0]  tnew_in;
   logic [4:0]  a3_in;
   logic [63:0] data_in;

   logic        v2, rw2, v1, rw1;
   logic [31:0] pc2, pc1, bc2, bc1;
   logic [1:0]  t2, t1, trw2, ttn1;
   logic [4:0]  a32, a31, ta31;
   logic [63:0] d2, d1;
   logic [9:0]  ta32;
   logic [3:0]  ttn2;
   logic        trw1;

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(64), .TNEW_W(2), .DEPTH(2), .TNEW_DEC(1)) dut (
      .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_in(valid_in),
      .pc_in(pc_in), .tnew_in(tnew_in), .regwrite_in(regwrite_in), .a3_in(a3_in),
      .data_in(data_in), .valid_out(v2), .pc_out(pc2), .tnew_out(t2),
      .regwrite_out(rw2), .a3_out(a32), .data_out(d2), .tap_a3(ta32),
      .tap_regwrite(trw2), .tap_tnew(ttn2), .bubble_cnt(bc2));

   pipe_stage_reg #(.DATA_W(64), .TNEW_W(2), .DEPTH(1), .TNEW_DEC(1)) dut1 (
      .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_in(valid_in),
      .pc_in(pc_in), .tnew_in(tnew_in), .regwrite_in(regwrite_in), .a3_in(a3_in),
      .data_in(data_in), .valid_out(v1), .pc_out(pc1), .tnew_out(t1),
      .regwrite_out(rw1), .a3_out(a31), .data_out(d1), .tap_a3(ta31),
      .tap_regwrite(trw1), .tap_tnew(ttn1), .bubble_cnt(bc1));

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Model: each entry remembers its original T_new and how many advances it has made.
   typedef struct {
      logic        v;
      logic [31:0] pc;
      int          t0;
      int          adv;
      logic        rw;
      logic [4:0]  a3;
      logic [63:0] d;
   } ent_t;

   ent_t        m [2][4];
   int          mdepth [2] = '{2, 1};
   logic [31:0] mcnt [2];

   function automatic ent_t bubble(input logic [31:0] pc);
      ent_t e;
      e.v = 1'b0; e.pc = pc; e.t0 = 0; e.adv = 0; e.rw = 1'b0; e.a3 = '0; e.d = '0;
      return e;
   endfunction

   task automatic model_edge();
      ent_t e;
      for (int i = 0; i < 2; i++) begin
         if (!reset) begin
            for (int k = 0; k < 4; k++) m[i][k] = bubble(32'd0);
            mcnt[i] = '0;
         end else begin
            if (!m[i][mdepth[i]-1].v && mcnt[i] != 32'hFFFF_FFFF) mcnt[i] = mcnt[i] + 1;
            if (flush) e = bubble(pc_in);
            else begin
               e.v = valid_in; e.pc = pc_in; e.t0 = int'(tnew_in); e.adv = 1;
               e.rw = regwrite_in && valid_in && (a3_in != 0); e.a3 = a3_in; e.d = data_in;
            end
            if (en) begin
               for (int k = mdepth[i]-1; k >= 1; k--) begin
                  m[i][k] = m[i][k-1];
                  m[i][k].adv++;
               end
               m[i][0] = e;
            end else if (flush) m[i][0] = e;
         end
      end
   endtask

   function automatic logic [1:0] exp_tnew(input ent_t e);
      return (e.t0 > e.adv) ? 2'(e.t0 - e.adv) : 2'd0;
   endfunction

   task automatic cmp_one(input int i, input logic v, input logic [31:0] pc, input logic [1:0] t,
                          input logic rw, input logic [4:0] a3, input logic [63:0] d,
                          input logic [9:0] ta3, input logic [1:0] trw, input logic [3:0] ttn,
                          input logic [31:0] bc);
      ent_t        last;
      logic [9:0]  ea3;
      logic [1:0]  erw;
      logic [3:0]  etn;
      last = m[i][mdepth[i]-1];
      ea3 = '0; erw = '0; etn = '0;
      for (int k = 0; k < mdepth[i]; k++) begin
         ea3[5*k +: 5] = m[i][k].a3;
         erw[k]        = m[i][k].rw;
         etn[2*k +: 2] = exp_tnew(m[i][k]);
      end
      chk($sformatf("d%0d valid_out", mdepth[i]), 64'(v), 64'(last.v));
      chk($sformatf("d%0d pc_out", mdepth[i]), 64'(pc), 64'(last.pc));
      chk($sformatf("d%0d tnew_out", mdepth[i]), 64'(t), 64'(exp_tnew(last)));
      chk($sformatf("d%0d regwrite_out", mdepth[i]), 64'(rw), 64'(last.rw));
      chk($sformatf("d%0d a3_out", mdepth[i]), 64'(a3), 64'(last.a3));
      chk($sformatf("d%0d data_out", mdepth[i]), d, last.d);
      chk($sformatf("d%0d tap_a3", mdepth[i]), 64'(ta3), 64'(ea3));
      chk($sformatf("d%0d tap_regwrite", mdepth[i]), 64'(trw), 64'(erw));
      chk($sformatf("d%0d tap_tnew", mdepth[i]), 64'(ttn), 64'(etn));
      chk($sformatf("d%0d bubble_cnt", mdepth[i]), 64'(bc), 64'(mcnt[i]));
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      cmp_one(0, v2, pc2, t2, rw2, a32, d2, ta32, trw2, ttn2, bc2);
      cmp_one(1, v1, pc1, t1, rw1, a31, d1, {5'd0, ta31}, {1'b0, trw1}, {2'd0, ttn1}, bc1);
   endtask

   task automatic drive(input logic e, input logic f, input logic v, input logic [31:0] pc,
                        input logic [1:0] t, input logic rw, input logic [4:0] a3,
                        input logic [63:0] d);
      en = e; flush = f; valid_in = v; pc_in = pc; tnew_in = t;
      regwrite_in = rw; a3_in = a3; data_in = d;
   endtask

   typedef struct {
      logic en, fl, v; logic [31:0] pc; logic [1:0] t; logic rw; logic [4:0] a3; logic [63:0] d;
      logic ev; logic [31:0] epc; logic [1:0] et; logic erw; logic [4:0] ea3; logic [63:0] ed;
   } vec_t;

   function automatic vec_t mk(input logic e, input logic f, input logic v, input logic [31:0] pc,
                               input logic [1:0] t, input logic rw, input logic [4:0] a3,
                               input logic [63:0] d, input logic ev, input logic [31:0] epc,
                               input logic [1:0] et, input logic erw, input logic [4:0] ea3,
                               input logic [63:0] ed);
      vec_t r;
      r.en = e; r.fl = f; r.v = v; r.pc = pc; r.t = t; r.rw = rw; r.a3 = a3; r.d = d;
      r.ev = ev; r.epc = epc; r.et = et; r.erw = erw; r.ea3 = ea3; r.ed = ed;
      return r;
   endfunction

   vec_t tbl [11];

   initial begin
      // DEPTH=1 expectations after each edge: $0 suppression, invalid write, 3-cycle stall,
      // flush with and without en, tnew saturation at 0.
      tbl[0]  = mk(1,0,1,32'h100,3,1, 0,64'h11, 1,32'h100,2,0, 0,64'h11);
      tbl[1]  = mk(1,0,0,32'h104,1,1, 5,64'h22, 0,32'h104,0,0, 5,64'h22);
      tbl[2]  = mk(1,0,1,32'h108,2,1, 7,64'h33, 1,32'h108,1,1, 7,64'h33);
      tbl[3]  = mk(0,0,1,32'h10C,3,1, 9,64'h44, 1,32'h108,1,1, 7,64'h33);
      tbl[4]  = mk(0,0,1,32'h10C,3,1, 9,64'h44, 1,32'h108,1,1, 7,64'h33);
      tbl[5]  = mk(0,0,1,32'h10C,3,1, 9,64'h44, 1,32'h108,1,1, 7,64'h33);
      tbl[6]  = mk(1,0,1,32'h10C,3,1, 9,64'h44, 1,32'h10C,2,1, 9,64'h44);
      tbl[7]  = mk(0,1,1,32'h110,3,1, 3,64'h55, 0,32'h110,0,0, 0,64'h0);
      tbl[8]  = mk(1,1,1,32'h114,2,1, 3,64'h66, 0,32'h114,0,0, 0,64'h0);
      tbl[9]  = mk(1,0,1,32'h118,0,1,31,64'h77, 1,32'h118,0,1,31,64'h77);
      tbl[10] = mk(1,0,1,32'h11C,1,0, 6,64'h88, 1,32'h11C,0,0, 6,64'h88);

      // Reset with random inputs
      reset = 1'b0;
      for (int c = 0; c < 2; c++) begin
         drive(1'($urandom), 1'($urandom), 1'($urandom), $urandom, 2'($urandom),
               1'($urandom), 5'($urandom), {$urandom, $urandom});
         tick();
      end
      chk("reset valid_out", 64'(v2), 64'd0);
      chk("reset tap_a3", 64'(ta32), 64'd0);
      chk("reset bubble_cnt", 64'(bc2), 64'd0);
      reset = 1'b1;
      drive(1, 0, 0, 32'd0, 2'd0, 1'b0, 5'd0, 64'd0);
      for (int c = 0; c < 3; c++) tick();
      chk("idle bubble_cnt", 64'(bc2), 64'd3);
      chk("idle bubble_cnt d1", 64'(bc1), 64'd3);

      for (int r = 0; r < 11; r++) begin
         drive(tbl[r].en, tbl[r].fl, tbl[r].v, tbl[r].pc, tbl[r].t, tbl[r].rw, tbl[r].a3, tbl[r].d);
         tick();
         chk($sformatf("tbl%0d valid", r), 64'(v1), 64'(tbl[r].ev));
         chk($sformatf("tbl%0d pc", r), 64'(pc1), 64'(tbl[r].epc));
         chk($sformatf("tbl%0d tnew", r), 64'(t1), 64'(tbl[r].et));
         chk($sformatf("tbl%0d regwrite", r), 64'(rw1), 64'(tbl[r].erw));
         chk($sformatf("tbl%0d a3", r), 64'(a31), 64'(tbl[r].ea3));
         chk($sformatf("tbl%0d data", r), d1, tbl[r].ed);
      end

      // DEPTH=2 pass-through with tnew decrementing per stage
      drive(1, 0, 1, 32'h3000, 2'd2, 1'b1, 5'd8, 64'hDEAD);
      tick();
      chk("pt tap_tnew s0", 64'(ttn2[1:0]), 64'd1);
      chk("pt tap_a3 s0", 64'(ta32[4:0]), 64'd8);
      drive(1, 0, 0, 32'h3004, 2'd0, 1'b0, 5'd0, 64'd0);
      tick();
      chk("pt pc_out", 64'(pc2), 64'h3000);
      chk("pt tnew_out", 64'(t2), 64'd0);
      chk("pt regwrite_out", 64'(rw2), 64'd1);
      chk("pt a3_out", 64'(a32), 64'd8);
      chk("pt data_out", d2, 64'hDEAD);

      // DEPTH=2 flush during stall: stage0 bubbled, stage1 held
      drive(1, 0, 1, 32'h200, 2'd3, 1'b1, 5'd4, 64'hA4);
      tick();
      drive(1, 0, 1, 32'h204, 2'd3, 1'b1, 5'd9, 64'hA9);
      tick();
      chk("fs taps before", 64'(ta32), 64'({5'd4, 5'd9}));
      drive(0, 1, 1, 32'h208, 2'd3, 1'b1, 5'd12, 64'hAC);
      tick();
      chk("fs taps after", 64'(ta32), 64'({5'd4, 5'd0}));
      chk("fs stage1 pc", 64'(pc2), 64'h200);
      chk("fs stage1 valid", 64'(v2), 64'd1);
      drive(1, 0, 0, 32'h20C, 2'd0, 1'b0, 5'd0, 64'd0);
      tick();
      chk("fs bubble pc", 64'(pc2), 64'h208);
      chk("fs bubble valid", 64'(v2), 64'd0);
      chk("fs bubble a3", 64'(a32), 64'd0);

      // Counter saturation
      for (int c = 0; c < 2; c++) tick();
      dut.bubble_q  = 32'hFFFF_FFFE;
      dut1.bubble_q = 32'hFFFF_FFFE;
      mcnt[0] = 32'hFFFF_FFFE;
      mcnt[1] = 32'hFFFF_FFFE;
      for (int c = 0; c < 3; c++) tick();
      chk("sat bubble_cnt", 64'(bc2), 64'hFFFF_FFFF);
      chk("sat bubble_cnt d1", 64'(bc1), 64'hFFFF_FFFF);

      // Random traffic
      for (int c = 0; c < 400; c++) begin
         reset = ($urandom_range(0, 39) != 0);
         drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), 1'($urandom),
               $urandom, 2'($urandom), 1'($urandom),
               ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom), {$urandom, $urandom});
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
